// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
package counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

    // Register width needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits a one-cycle step strobe on every PRESCALE-th enabled cycle.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk50m,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("tick_prescaler: PRESCALE must be >= 1");
        end

        if (PRESCALE <= 1) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk50m, rst, clr_i};
            assign tick_o = en_i;
        end else begin : g_div
            localparam int PW = clog2_min1(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_reg;

            assign tick_o = en_i && (pre_reg == PRE_LAST);

            always_ff @(posedge clk50m) begin
                if (rst || clr_i) begin
                    pre_reg <= '0;
                end else if (en_i) begin
                    pre_reg <= (pre_reg == PRE_LAST) ? '0 : pre_reg + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with prescaled enable, load/clear, wrap or saturate
// boundary handling, terminal-count pulse and sticky overflow flag.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULO   = 256,
    parameter int              PRESCALE = 1
) (
    input  logic             clk50m,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("mod_updown_counter: WIDTH must be 1..32");
        end
        if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
            $error("mod_updown_counter: MODULO must be 2..2**WIDTH");
        end
    endgenerate

    // One extra bit so MODULO == 2**WIDTH compares without overflow.
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULO - 1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;
    logic             step;
    logic             at_top, at_zero;
    logic [WIDTH-1:0] load_clamped;
    dir_e             dir;
    mode_e            mode;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk50m (clk50m),
        .rst    (rst),
        .clr_i  (clr | load),
        .en_i   (enable),
        .tick_o (step)
    );

    assign dir          = dir_e'(up);
    assign mode         = mode_e'(sat_mode);
    assign at_top       = ({1'b0, count_reg} == LAST);
    assign at_zero      = (count_reg == '0);
    assign load_clamped = ({1'b0, load_val} > LAST) ? LAST[WIDTH-1:0] : load_val;

    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        ovf_next   = ovf_reg;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (at_top) begin
                    tc_next  = 1'b1;
                    ovf_next = 1'b1;
                    if (mode == MODE_WRAP) count_next = '0;
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    tc_next  = 1'b1;
                    ovf_next = 1'b1;
                    if (mode == MODE_WRAP) count_next = LAST[WIDTH-1:0];
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk50m) begin
        if (rst) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign ovf   = ovf_reg;

endmodule
